// File: rtl/pulse_burst_pkg.sv
// -----------------------------------------------------------------------------
// pulse_burst_pkg
// Shared definitions for the pulse burst generator:
//   - state_t        : burst FSM state encoding (IDLE, HIGH, LOW, FINISH)
//   - DEF_CNT_W      : default width of high/low lengths and the phase counter
//   - DEF_LEN_W      : default width of burst length and the pulse counter
// -----------------------------------------------------------------------------
package pulse_burst_pkg;

   localparam int DEF_CNT_W = 16;
   localparam int DEF_LEN_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HIGH   = 2'd1,
      LOW    = 2'd2,
      FINISH = 2'd3
   } state_t;

endpackage

// File: rtl/burst_down_counter.sv
// -----------------------------------------------------------------------------
// burst_down_counter
// Loadable down-counter with a zero flag. Load has priority over decrement,
// and decrement holds at zero so the count can never wrap.
// Ports:
//   clk       : system clock, rising edge
//   reset_p   : asynchronous active-high reset (count cleared)
//   load      : load load_val this cycle
//   dec       : decrement by one (ignored when already zero)
//   load_val  : value to load
//   zero      : count is zero
// -----------------------------------------------------------------------------
module burst_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_p,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && !zero)
         cnt <= cnt - ONE;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// -----------------------------------------------------------------------------
// pulse_burst_gen
// Expands a single-cycle start strobe into a train of burst_len pulses, each
// high_len cycles high followed by low_len cycles low. Lengths are latched at
// the accepted start; a zero high/low length behaves as one cycle.
// Ports:
//   clk        : system clock, rising edge
//   reset_p    : asynchronous active-high reset
//   start      : strobe, begins a burst (ignored if stop is also high)
//   stop       : strobe, aborts a burst in progress without done
//   burst_len  : pulses per burst (0 = no pulses, done only)
//   high_len   : high cycles per pulse
//   low_len    : low cycles after each pulse
//   pulse_out  : registered pulse train
//   busy       : registered, high while pulses/gaps are being produced
//   done       : registered one-cycle strobe on normal completion
// Build option:
//   PULSE_BURST_RETRIGGER_EN : when defined, start during a burst re-latches
//                              lengths and restarts; otherwise it is ignored.
// -----------------------------------------------------------------------------
module pulse_burst_gen
   import pulse_burst_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic             start,
   input  logic             stop,
   input  logic [LEN_W-1:0] burst_len,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   output logic             pulse_out,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
   localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

   state_t           state;
   logic [CNT_W-1:0] hi_m1_in, lo_m1_in;
   logic [CNT_W-1:0] hi_m1_q, lo_m1_q;
   logic [LEN_W-1:0] bl_m1_in;
   logic             in_burst, can_start, accept, abort;

   // Counter controls
   logic             ph_load, ph_dec, ph_zero;
   logic [CNT_W-1:0] ph_val;
   logic             pl_load, pl_dec, pl_zero;

   // Counters hold length-1; a zero length saturates to 0 so it runs 1 cycle.
   assign hi_m1_in = (high_len  == '0) ? '0 : high_len  - ONE_C;
   assign lo_m1_in = (low_len   == '0) ? '0 : low_len   - ONE_C;
   assign bl_m1_in = (burst_len == '0) ? '0 : burst_len - ONE_L;

   assign in_burst = (state == HIGH) || (state == LOW);

`ifdef PULSE_BURST_RETRIGGER_EN
   assign can_start = (state == IDLE) || in_burst;
`else
   assign can_start = (state == IDLE);
`endif

   // stop beats start when both arrive together
   assign accept = start && !stop && can_start;
   assign abort  = stop && in_burst;

   // Phase counter times the current HIGH/LOW stretch; pulse counter holds
   // the number of pulses still to come after the current one.
   always_comb begin
      ph_load = 1'b0;
      ph_dec  = 1'b0;
      ph_val  = hi_m1_in;
      pl_load = 1'b0;
      pl_dec  = 1'b0;
      if (accept) begin
         ph_load = 1'b1;
         pl_load = 1'b1;
      end else if (!abort) begin
         case (state)
            HIGH: begin
               if (ph_zero) begin
                  ph_load = 1'b1;
                  ph_val  = lo_m1_q;
               end else begin
                  ph_dec = 1'b1;
               end
            end
            LOW: begin
               if (!ph_zero) begin
                  ph_dec = 1'b1;
               end else if (!pl_zero) begin
                  ph_load = 1'b1;
                  ph_val  = hi_m1_q;
                  pl_dec  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   burst_down_counter #(.W(CNT_W)) u_phase_cnt (
      .clk      (clk),
      .reset_p  (reset_p),
      .load     (ph_load),
      .dec      (ph_dec),
      .load_val (ph_val),
      .zero     (ph_zero)
   );

   burst_down_counter #(.W(LEN_W)) u_pulse_cnt (
      .clk      (clk),
      .reset_p  (reset_p),
      .load     (pl_load),
      .dec      (pl_dec),
      .load_val (bl_m1_in),
      .zero     (pl_zero)
   );

   // Outputs are registered alongside the state so each one is a flop Q and
   // reflects the state it belongs to in the same cycle.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state     <= IDLE;
         pulse_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hi_m1_q   <= '0;
         lo_m1_q   <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            hi_m1_q <= hi_m1_in;
            lo_m1_q <= lo_m1_in;
            if (burst_len == '0) begin
               // Empty burst: straight to the completion strobe.
               state     <= FINISH;
               pulse_out <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b1;
            end else begin
               state     <= HIGH;
               pulse_out <= 1'b1;
               busy      <= 1'b1;
            end
         end else if (abort) begin
            state     <= IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               HIGH: begin
                  if (ph_zero) begin
                     state     <= LOW;
                     pulse_out <= 1'b0;
                  end
               end
               LOW: begin
                  if (ph_zero) begin
                     if (pl_zero) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state     <= HIGH;
                        pulse_out <= 1'b1;
                     end
                  end
               end
               FINISH: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_burst_gen
// Scoreboard bench: the driver pushes the expected {pulse_out,busy,done} for
// each clock it issues; a monitor pops and compares on every falling edge.
// Expected traces are built from the burst timing rules (high/low runs, done
// strobe) independent of the DUT's FSM.
// -----------------------------------------------------------------------------
module tb_pulse_burst_gen;

   localparam int CNT_W = 16;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             reset_p;
   logic             start, stop;
   logic [LEN_W-1:0] burst_len;
   logic [CNT_W-1:0] high_len, low_len;
   logic             pulse_out, busy, done;

   pulse_burst_gen #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset_p   (reset_p),
      .start     (start),
      .stop      (stop),
      .burst_len (burst_len),
      .high_len  (high_len),
      .low_len   (low_len),
      .pulse_out (pulse_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] v;
      int         tn;
      int         idx;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] plan[$];
   int         checks = 0;
   int         errors = 0;
   int         tnum   = 0;
   int         sidx   = 0;

   // Monitor: one comparison per queued expectation, on the falling edge.
   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if ({pulse_out, busy, done} !== x.v) begin
               errors++;
               $display("FAIL test%0d cycle%0d: pulse/busy/done got %b expected %b",
                        x.tn, x.idx, {pulse_out, busy, done}, x.v);
            end
         end
      end
   end

   task automatic chk_now(input string name, input logic [2:0] want);
      checks++;
      if ({pulse_out, busy, done} !== want) begin
         errors++;
         $display("FAIL %s: pulse/busy/done got %b expected %b",
                  name, {pulse_out, busy, done}, want);
      end
   endtask

   // One clock: expectation is for the outputs after this rising edge.
   task automatic step(input logic [2:0] e);
      exp_t x;
      @(posedge clk);
      x.v = e; x.tn = tnum; x.idx = sidx;
      sb.push_back(x);
      sidx++;
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   // Append the trace of one complete burst, starting the cycle after start.
   task automatic add_wave(input int bl, input int hi, input int lo);
      int h, l;
      h = (hi == 0) ? 1 : hi;
      l = (lo == 0) ? 1 : lo;
      for (int p = 0; p < bl; p++) begin
         repeat (h) plan.push_back(3'b110);
         repeat (l) plan.push_back(3'b010);
      end
      plan.push_back(3'b001);
   endtask

   // Run a burst; optionally stop at step stop_at, change lengths at chg_at,
   // or issue a second start (with new lengths) at rt_at.
   task automatic run(input int bl, input int hi, input int lo,
                      input int stop_at, input int chg_at, input int rt_at,
                      input int nbl, input int nhi, input int nlo);
      tnum++;
      sidx = 0;
      plan.delete();
      add_wave(bl, hi, lo);
      if (stop_at >= 0) begin
         while (plan.size() > stop_at) void'(plan.pop_back());
         repeat (4) plan.push_back(3'b000);
      end
`ifdef PULSE_BURST_RETRIGGER_EN
      if (rt_at >= 0) begin
         while (plan.size() > rt_at) void'(plan.pop_back());
         add_wave(nbl, nhi, nlo);
      end
`endif
      repeat (2) plan.push_back(3'b000);
      for (int k = 0; k < plan.size(); k++) begin
         if (k == 0) begin
            start = 1'b1;
            burst_len = LEN_W'(bl); high_len = CNT_W'(hi); low_len = CNT_W'(lo);
         end
         if (k == chg_at) begin
            burst_len = LEN_W'(nbl); high_len = CNT_W'(nhi); low_len = CNT_W'(nlo);
         end
         if (k == rt_at) begin
            start = 1'b1;
            burst_len = LEN_W'(nbl); high_len = CNT_W'(nhi); low_len = CNT_W'(nlo);
         end
         if (k == stop_at) stop = 1'b1;
         step(plan[k]);
      end
   endtask

   task automatic summary;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
   endtask

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: simulation still running at time limit");
      summary();
      $finish;
   end

   initial begin : driver
      reset_p = 1'b1;
      start = 1'b0; stop = 1'b0;
      burst_len = '0; high_len = '0; low_len = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_now("reset_state", 3'b000);
      reset_p = 1'b0;
      step(3'b000);
      step(3'b000);

      // Basic: 3 pulses, 2 high / 3 low
      run(3, 2, 3, -1, -1, -1, 0, 0, 0);
      // Zero high/low treated as one cycle
      run(2, 0, 0, -1, -1, -1, 0, 0, 0);
      // Empty burst: done the cycle after start, no pulses
      run(0, 5, 5, -1, -1, -1, 0, 0, 0);
      // Abort during first cycle of 2nd HIGH of a 4-pulse burst
      run(4, 3, 2, 6, -1, -1, 0, 0, 0);
      // Full burst after the abort
      run(2, 1, 1, -1, -1, -1, 0, 0, 0);

      // start and stop together in IDLE: nothing happens
      tnum++; sidx = 0;
      start = 1'b1; stop = 1'b1;
      burst_len = 8'd3; high_len = 16'd2; low_len = 16'd2;
      repeat (4) step(3'b000);
      // stop while IDLE: nothing happens
      tnum++; sidx = 0;
      stop = 1'b1;
      repeat (2) step(3'b000);

      // Lengths changed mid-burst: waveform unchanged
      run(2, 3, 2, -1, 2, -1, 7, 1, 9);
      // start during a burst (ignored, or restart when retrigger is built in)
      run(3, 2, 2, -1, -1, 4, 1, 3, 1);

      // Async reset in the middle of a HIGH phase
      tnum++; sidx = 0;
      start = 1'b1;
      burst_len = 8'd3; high_len = 16'd5; low_len = 16'd2;
      step(3'b110);
      step(3'b110);
      @(negedge clk);
      #1;
      reset_p = 1'b1;
      #1;
      chk_now("async_reset_immediate", 3'b000);
      @(posedge clk);
      #1;
      chk_now("reset_held", 3'b000);
      reset_p = 1'b0;
      repeat (3) step(3'b000);
      // FSM back in IDLE and accepts a new burst
      run(1, 2, 1, -1, -1, -1, 0, 0, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      summary();
      $finish;
   end

endmodule

// File: doc/pulse_burst_gen.md
Name: pulse_burst_gen

Overview:
- Inverse of the team's edge-detect path: takes a single-cycle event strobe and expands it into a timed, level-valued pulse train.
- Typical use: a button p_edge triggers a buzzer chirp or an LED blink burst on the fan board.
- Timing is programmable per burst: pulse count, high width and low width, all in clock cycles.
- Sits between the button/edge-detect layer and the output pin drivers.

Parameters:
- CNT_W, 16, width of high_len/low_len and of the phase counter.
- LEN_W, 8, width of burst_len and of the pulse counter.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset_p  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle strobe; begins a burst.
- stop  input  1  single-cycle strobe; aborts the burst in progress.
- burst_len  input  LEN_W  number of pulses per burst; sampled at accepted start.
- high_len  input  CNT_W  cycles high per pulse; sampled at accepted start.
- low_len  input  CNT_W  cycles low after each pulse; sampled at accepted start.
- pulse_out  output  1  registered pulse train.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle strobe when a burst completes normally.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset_p).
- Reset: state=IDLE; pulse_out=0, busy=0, done=0; all counters and latched lengths cleared.
- FSM states:
  - IDLE: start=1 and stop=0 → latch lengths, then go to HIGH (or FINISH if burst_len=0).
  - HIGH: pulse_out=1 for high_len cycles → LOW.
  - LOW: pulse_out=0 for low_len cycles → HIGH if pulses remain, else FINISH.
  - FINISH: done=1 for exactly one cycle, busy=0 → IDLE.
- Zero lengths: high_len=0 and low_len=0 are each treated as 1. burst_len=0 produces no pulses; done asserts in the cycle after start.
- Latency: start sampled at edge t → pulse_out=1 and busy=1 in cycle t+1.
- Each pulse occupies exactly high_len+low_len cycles. Total busy time is burst_len*(high_len+low_len). done asserts in the cycle immediately after the final low cycle.
- Inputs change mid-burst: no effect; only the values latched at start are used.
- start while busy: ignored (see optional feature).
- stop while busy: next cycle state=IDLE, pulse_out=0, busy=0; done is NOT asserted.
- stop and start in the same cycle: stop wins; start is ignored.
- stop while IDLE: no effect.
- Async reset mid-burst: all outputs drop to 0 immediately; no done.
- Counters: down-counters loaded with length-1; no wrap-around is possible.
- Outputs are glitch-free: pulse_out, busy and done all come directly from flops.

Optional Feature:
- Macro: PULSE_BURST_RETRIGGER_EN.
- Defined: start while busy (and stop=0) re-latches all lengths and restarts the burst. The next cycle is the first HIGH cycle of the new burst. done is not asserted for the abandoned burst.
- Undefined: start while busy is ignored.

Decomposition:
- Package pulse_burst_pkg holds:
  - state enum: IDLE, HIGH, LOW, FINISH.
  - default width constants (CNT_W, LEN_W).
- Sub-module burst_down_counter: loadable down-counter with a zero flag. Instantiated twice: CNT_W-wide for the phase counter, LEN_W-wide for the pulse counter.

Test Plan:
- Basic burst: burst_len=3, high=2, low=3, start at cycle 10 → pulse_out high cycles 11-12, 16-17, 21-22; busy cycles 11-25; done=1 at cycle 26 only.
- Zero handling: burst_len=2, high=0, low=0 → pulse_out 1,0,1,0 over cycles t+1..t+4; done at t+5. burst_len=0 → pulse_out stays 0; done at t+1.
- Abort: stop during the 2nd HIGH of a 4-pulse burst → next cycle pulse_out=0, busy=0; done never asserts; a new start afterwards runs a full burst.
- Priority: start and stop asserted together in IDLE → no burst, busy stays 0. Lengths changed mid-burst → waveform unchanged.
- Retrigger: start during a burst with PULSE_BURST_RETRIGGER_EN undefined → ignored. With the macro defined → next cycle is HIGH with the newly latched lengths; only one done, at the end of the new burst.
- Reset: reset_p asserted mid-HIGH (asynchronous, between clock edges) → pulse_out/busy/done read 0 immediately; after release, the FSM is IDLE and waits for start.
